// File: rtl/obi_serial_issue_bridge.sv
// obi_serial_issue_bridge
// Single-clock OBI adapter that sits in front of the fast-primary OBI CDC.
// It issues one downstream transaction at a time and keeps addr/we/be/wdata
// stable until that transaction is answered. The CDC's stretched rvalid level
// is reduced to a one-cycle upstream rvalid pulse. A stall in WAIT longer than
// TIMEOUT cycles produces an error response. The late downstream response is
// then absorbed in DRAIN, so it never reaches the upstream port.
//
// Handshake semantics:
//   upstream   - a request is accepted in the cycle where up_req_i and
//                up_gnt_o are both high. up_gnt_o is combinational and is
//                only offered in IDLE. The response is a single-cycle
//                up_rvalid_o pulse; up_rdata_o and up_err_o are qualified by
//                that pulse and hold their values until the next response.
//   downstream - dn_req_o stays high until a dn_gnt_i pulse is seen. The
//                response is the rising edge of the dn_rvalid_i level.
//                dn_rdata_i is sampled on that edge.
//
// busy_o exposes the FSM state to checkers: it is low only in IDLE.

module obi_serial_issue_bridge #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                TIMEOUT   = 1024,
   parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(32'hDEAD_BEEF)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // upstream (core side)
   input  logic                  up_req_i,
   output logic                  up_gnt_o,
   input  logic [ADDR_W-1:0]     up_addr_i,
   input  logic                  up_we_i,
   input  logic [DATA_W/8-1:0]   up_be_i,
   input  logic [DATA_W-1:0]     up_wdata_i,
   output logic                  up_rvalid_o,
   output logic [DATA_W-1:0]     up_rdata_o,
   output logic                  up_err_o,
   // downstream (CDC side)
   output logic                  dn_req_o,
   input  logic                  dn_gnt_i,
   output logic [ADDR_W-1:0]     dn_addr_o,
   output logic                  dn_we_o,
   output logic [DATA_W/8-1:0]   dn_be_o,
   output logic [DATA_W-1:0]     dn_wdata_o,
   input  logic                  dn_rvalid_i,
   input  logic [DATA_W-1:0]     dn_rdata_i,
   output logic                  busy_o
);

   // A zero-width counter is illegal, so a disabled timeout keeps one dummy bit.
   localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             rv_q;
   logic             rv_rise;
   logic             timeout_hit;

   // Response-edge and timeout decode; only the rising edge of rvalid counts.
   always_comb begin
      rv_rise     = dn_rvalid_i & ~rv_q;
      timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
   end

   assign up_gnt_o = up_req_i & (state == S_IDLE) & ~rst_i;
   assign busy_o   = (state != S_IDLE);

   // Track the previous rvalid level for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rv_q <= 1'b0;
      end else begin
         rv_q <= dn_rvalid_i;
      end
   end

   // Capture the request payload on grant only, so it stays stable downstream.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dn_addr_o  <= '0;
         dn_we_o    <= 1'b0;
         dn_be_o    <= '0;
         dn_wdata_o <= '0;
      end else if (up_gnt_o) begin
         dn_addr_o  <= up_addr_i;
         dn_we_o    <= up_we_i;
         dn_be_o    <= up_be_i;
         dn_wdata_o <= up_wdata_i;
      end
   end

   // Issue FSM: sequence request, wait, response or timeout, and drain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         dn_req_o    <= 1'b0;
         cnt         <= '0;
         up_rvalid_o <= 1'b0;
         up_rdata_o  <= '0;
         up_err_o    <= 1'b0;
      end else begin
         up_rvalid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               // An rvalid edge arriving here is stale and is ignored.
               if (up_gnt_o) begin
                  state    <= S_REQ;
                  dn_req_o <= 1'b1;
               end
            end
            S_REQ: begin
               // A request is never withdrawn once issued, so REQ has no timeout.
               if (dn_gnt_i) begin
                  state    <= S_WAIT;
                  dn_req_o <= 1'b0;
                  cnt      <= '0;
               end
            end
            S_WAIT: begin
               cnt <= cnt + CNT_ONE;
               if (rv_rise) begin
                  // A real response beats a timeout in the same cycle.
                  state       <= S_IDLE;
                  up_rvalid_o <= 1'b1;
                  up_rdata_o  <= dn_rdata_i;
                  up_err_o    <= 1'b0;
               end else if (timeout_hit) begin
                  state       <= S_DRAIN;
                  up_rvalid_o <= 1'b1;
                  up_rdata_o  <= ERR_RDATA;
                  up_err_o    <= 1'b1;
               end
            end
            S_DRAIN: begin
               // Swallow the late response; upstream has already been answered.
               if (rv_rise) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state    <= S_IDLE;
               dn_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obi_serial_issue_bridge.sv
// Testbench for obi_serial_issue_bridge.
// A driver acts as both the core and the downstream slave. For every
// transaction it pushes the response that the bridge rules predict, together
// with its cycle. A negedge monitor compares each upstream rvalid pulse (or
// the lack of one) against the head of that queue. It also checks that the
// held downstream fields match what was granted and that no grant is offered
// while the bridge is busy.

module tb_obi_serial_issue_bridge;

   localparam int          ADDR_W    = 32;
   localparam int          DATA_W    = 32;
   localparam int          BE_W      = DATA_W / 8;
   localparam int          TIMEOUT   = 16;
   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              up_req_i;
   logic              up_gnt_o;
   logic [ADDR_W-1:0] up_addr_i;
   logic              up_we_i;
   logic [BE_W-1:0]   up_be_i;
   logic [DATA_W-1:0] up_wdata_i;
   logic              up_rvalid_o;
   logic [DATA_W-1:0] up_rdata_o;
   logic              up_err_o;
   logic              dn_req_o;
   logic              dn_gnt_i;
   logic [ADDR_W-1:0] dn_addr_o;
   logic              dn_we_o;
   logic [BE_W-1:0]   dn_be_o;
   logic [DATA_W-1:0] dn_wdata_o;
   logic              dn_rvalid_i;
   logic [DATA_W-1:0] dn_rdata_i;
   logic              busy_o;

   obi_serial_issue_bridge #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .TIMEOUT  (TIMEOUT),
      .ERR_RDATA(ERR_RDATA)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .up_req_i   (up_req_i),
      .up_gnt_o   (up_gnt_o),
      .up_addr_i  (up_addr_i),
      .up_we_i    (up_we_i),
      .up_be_i    (up_be_i),
      .up_wdata_i (up_wdata_i),
      .up_rvalid_o(up_rvalid_o),
      .up_rdata_o (up_rdata_o),
      .up_err_o   (up_err_o),
      .dn_req_o   (dn_req_o),
      .dn_gnt_i   (dn_gnt_i),
      .dn_addr_o  (dn_addr_o),
      .dn_we_o    (dn_we_o),
      .dn_be_o    (dn_be_o),
      .dn_wdata_o (dn_wdata_o),
      .dn_rvalid_i(dn_rvalid_i),
      .dn_rdata_i (dn_rdata_i),
      .busy_o     (busy_o)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk_i = ~clk_i;

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;

   // {err[64], rdata[63:32], due_cycle[31:0]}
   logic [64:0] exp_q[$];

   logic [ADDR_W-1:0] cur_addr  = '0;
   logic              cur_we    = 1'b0;
   logic [BE_W-1:0]   cur_be    = '0;
   logic [DATA_W-1:0] cur_wdata = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_idle_outputs(input string name);
      chk(name, {busy_o, dn_req_o, dn_we_o, dn_be_o, dn_addr_o, dn_wdata_o,
                 up_rvalid_o, up_err_o, up_rdata_o}, '0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk_i) begin
      logic        pending;
      logic [64:0] head;
      pending = 1'b0;
      head    = '0;
      if (!rst_i) begin
         if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (head[31:0] == cyc) pending = 1'b1;
         end
         if (up_rvalid_o || pending) chk("rvalid_timing", up_rvalid_o, pending);
         if (pending) begin
            void'(exp_q.pop_front());
            if (up_rvalid_o) begin
               chk("resp_err", up_err_o, head[64]);
               chk("resp_rdata", up_rdata_o, head[63:32]);
            end
         end
         if (up_gnt_o) chk("gnt_only_idle", busy_o, 1'b0);
         if (busy_o) chk("dn_fields_held", {dn_we_o, dn_be_o, dn_addr_o, dn_wdata_o},
                         {cur_we, cur_be, cur_addr, cur_wdata});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_cyc();
      @(negedge clk_i);
      #1;
   endtask

   // One full transaction. gnt_dly: cycles in REQ before dn_gnt.
   // rv_dly: cycles after WAIT entry at which rvalid rises.
   // keep: leave up_req high, with scrambled payload, for a back-to-back grant.
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                          input int rv_len, input logic [31:0] rdata, input bit keep);
      bit          got;
      bit          done;
      bit          err;
      int unsigned c0;
      int unsigned due;
      got  = 1'b0;
      done = 1'b0;
      up_req_i   = 1'b1;
      up_addr_i  = addr;
      up_we_i    = we;
      up_be_i    = be;
      up_wdata_i = wdata;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (up_gnt_o) begin
            got = 1'b1;
            break;
         end
         wait_cyc();
      end
      if (!got) begin
         chk("up_gnt_timeout", up_gnt_o, 1'b1);
         up_req_i = 1'b0;
         return;
      end
      cur_addr  = addr;
      cur_we    = we;
      cur_be    = be;
      cur_wdata = wdata;
      wait_cyc();
      chk("dn_req_latency", dn_req_o, 1'b1);
      if (keep) begin
         up_addr_i  = $urandom;
         up_we_i    = 1'($urandom_range(0, 1));
         up_be_i    = 4'($urandom_range(0, 15));
         up_wdata_i = $urandom;
      end else begin
         up_req_i = 1'b0;
      end
      repeat (gnt_dly) wait_cyc();
      dn_gnt_i = 1'b1;
      wait_cyc();
      dn_gnt_i = 1'b0;
      chk("dn_req_drop", dn_req_o, 1'b0);
      // First WAIT cycle: the model says a response rising within the first
      // TIMEOUT cycles wins; otherwise an error comes out TIMEOUT cycles in.
      c0  = cyc;
      err = (rv_dly >= TIMEOUT);
      due = err ? c0 + TIMEOUT : c0 + rv_dly + 1;
      exp_q.push_back({err, err ? ERR_RDATA : rdata, due});
      repeat (rv_dly) wait_cyc();
      dn_rvalid_i = 1'b1;
      dn_rdata_i  = rdata;
      repeat (rv_len) wait_cyc();
      dn_rvalid_i = 1'b0;
      dn_rdata_i  = $urandom;
      for (int k = 0; k < 100; k++) begin
         #1;
         if (!busy_o) begin
            done = 1'b1;
            break;
         end
         wait_cyc();
      end
      if (!done) chk("busy_timeout", busy_o, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_i       = 1'b1;
      up_req_i    = 1'b0;
      up_addr_i   = '0;
      up_we_i     = 1'b0;
      up_be_i     = '0;
      up_wdata_i  = '0;
      dn_gnt_i    = 1'b0;
      dn_rvalid_i = 1'b0;
      dn_rdata_i  = '0;
      repeat (3) @(posedge clk_i);
      wait_cyc();
      up_req_i = 1'b1;
      #1;
      chk("gnt_in_reset", up_gnt_o, 1'b0);
      up_req_i = 1'b0;
      rst_i    = 1'b0;
      #1;
      check_idle_outputs("reset_state");
      wait_cyc();

      // read: dn_gnt at N+5, rvalid held 3 cycles
      run_txn(32'h100, 1'b0, 4'hF, 32'h0, 4, 2, 3, 32'hA5A5_0001, 1'b0);
      // back-to-back with up_req held high
      run_txn(32'h4, 1'b1, 4'h3, 32'h1111_2222, 1, 3, 1, 32'h0000_0004, 1'b1);
      run_txn(32'h8, 1'b0, 4'hC, 32'h3333_4444, 0, 1, 1, 32'h0000_0008, 1'b0);
      // timeout, then late rvalid drained
      run_txn(32'h200, 1'b0, 4'hF, 32'h0, 1, 20, 3, 32'h5555_6666, 1'b0);
      run_txn(32'h204, 1'b1, 4'h1, 32'hCAFE_F00D, 0, 0, 2, 32'h7777_8888, 1'b0);
      // tie: rise on the last allowed cycle wins
      run_txn(32'h208, 1'b0, 4'hF, 32'h0, 2, TIMEOUT - 1, 2, 32'h9999_AAAA, 1'b0);
      // first cycle past the limit: error, then immediate drain
      run_txn(32'h20C, 1'b0, 4'hF, 32'h0, 0, TIMEOUT, 1, 32'hBBBB_CCCC, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         int rv_dly;
         int rv_len;
         bit keep;
         rv_dly = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 8)
                                              : $urandom_range(0, 8);
         rv_len = $urandom_range(1, 4);
         keep   = (rv_len == 1) && ($urandom_range(0, 1) == 1) && (i != 39);
         if (!up_req_i && $urandom_range(0, 3) == 0) begin
            // stale rvalid edge while idle must not produce a response
            dn_rvalid_i = 1'b1;
            dn_rdata_i  = $urandom;
            wait_cyc();
            dn_rvalid_i = 1'b0;
            wait_cyc();
         end
         run_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 6), rv_dly, rv_len, $urandom, keep);
      end
      up_req_i = 1'b0;
      repeat (3) wait_cyc();

      // reset in the middle of WAIT with a stale rvalid across it
      up_req_i   = 1'b1;
      up_addr_i  = 32'h300;
      up_we_i    = 1'b1;
      up_be_i    = 4'hF;
      up_wdata_i = 32'h0BAD_CAFE;
      #1;
      chk("gnt_before_reset_test", up_gnt_o, 1'b1);
      cur_addr  = 32'h300;
      cur_we    = 1'b1;
      cur_be    = 4'hF;
      cur_wdata = 32'h0BAD_CAFE;
      wait_cyc();
      up_req_i = 1'b0;
      dn_gnt_i = 1'b1;
      wait_cyc();
      dn_gnt_i = 1'b0;
      repeat (3) wait_cyc();
      chk("busy_before_reset", busy_o, 1'b1);
      rst_i       = 1'b1;
      dn_rvalid_i = 1'b1;
      dn_rdata_i  = 32'h1234_5678;
      wait_cyc();
      rst_i = 1'b0;
      check_idle_outputs("mid_txn_reset");
      repeat (3) wait_cyc();
      dn_rvalid_i = 1'b0;
      repeat (3) wait_cyc();
      chk("idle_after_reset", busy_o, 1'b0);

      // normal traffic still works after the reset
      run_txn(32'h400, 1'b0, 4'hF, 32'h0, 1, 2, 2, 32'hFEED_0001, 1'b0);
      repeat (5) wait_cyc();
      chk("exp_q_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
